// File: rtl/ber_window_monitor.sv
// ber_window_monitor: windowed bit-error accumulator gated by link lock, with result handshake,
// overrun flag and saturating lock-loss counter.
module ber_window_monitor #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic [6:0]       errorCounter,
  input  logic [3:0]       win_sel,
  input  logic             clear,
  input  logic             res_ack,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_err,
  output logic [3:0]       res_words,
  output logic             overrun,
  output logic [7:0]       lock_loss_count,
  output logic [1:0]       state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] settle_q, settle_d, ll_q, ll_d;
  logic [CNT_W-1:0] acc_q, acc_d, res_err_q, res_err_d;
  logic [19:0] word_q, word_d, len_m1;
  logic [3:0] ws_q, ws_d, ws_in, res_words_q, res_words_d;
  logic res_valid_q, res_valid_d, overrun_q, overrun_d, new_res;
  logic [6:0] ec;
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] sum_sat;
  assign ec = errorCounter > 7'd64 ? 7'd64 : errorCounter;
  assign ws_in = win_sel > 4'd10 ? 4'd10 : win_sel;
  // A 10-step shift wraps to zero in 20 bits, so the minus one still yields the all-ones last index.
  assign len_m1 = (20'd1024 << ws_q) - 20'd1;
  assign sum = {1'b0, acc_q} + {{(CNT_W-6){1'b0}}, ec};
  assign sum_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  always_comb begin
    state_d = state_q;
    settle_d = settle_q;
    acc_d = acc_q;
    word_d = word_q;
    ws_d = ws_q;
    ll_d = ll_q;
    new_res = 1'b0;
    if (!aligned) begin
      state_d = S_IDLE;
      settle_d = '0;
      acc_d = '0;
      word_d = '0;
      ll_d = (state_q != S_IDLE && ll_q != 8'hFF) ? ll_q + 8'd1 : ll_q;
    end else if (state_q == S_IDLE) begin
      state_d = S_SETTLE;
      settle_d = 8'd1;
    end else if (state_q == S_SETTLE) begin
      state_d = settle_q >= 8'(SETTLE_CYCLES - 1) ? S_MEASURE : S_SETTLE;
      settle_d = settle_q >= 8'(SETTLE_CYCLES - 1) ? 8'd0 : settle_q + 8'd1;
      ws_d = ws_in;
    end else begin
      new_res = word_q == len_m1;
      acc_d = new_res ? '0 : sum_sat;
      word_d = new_res ? '0 : word_q + 20'd1;
      ws_d = new_res ? ws_in : ws_q;
    end
    if (clear) begin
      acc_d = '0;
      word_d = '0;
      ll_d = '0;
      new_res = 1'b0;
    end
  end
  assign res_valid_d = new_res | (res_valid_q & ~res_ack);
  assign res_err_d = new_res ? sum_sat : res_err_q;
  assign res_words_d = new_res ? ws_q : res_words_q;
  assign overrun_d = clear ? 1'b0 : overrun_q | (new_res & res_valid_q & ~res_ack);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      settle_q <= '0;
      acc_q <= '0;
      word_q <= '0;
      ws_q <= '0;
      ll_q <= '0;
      res_valid_q <= 1'b0;
      res_err_q <= '0;
      res_words_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      acc_q <= acc_d;
      word_q <= word_d;
      ws_q <= ws_d;
      ll_q <= ll_d;
      res_valid_q <= res_valid_d;
      res_err_q <= res_err_d;
      res_words_q <= res_words_d;
      overrun_q <= overrun_d;
    end
  end
  assign state = state_q;
  assign res_valid = res_valid_q;
  assign res_err = res_err_q;
  assign res_words = res_words_q;
  assign overrun = overrun_q;
  assign lock_loss_count = ll_q;
endmodule

// File: doc/ber_window_monitor.md
BER_WINDOW_MONITOR -- requirements
Module: ber_window_monitor

Interface
REQ-001 SETTLE_CYCLES, 16, aligned-high cycles ignored after lock before measuring (1..255).
REQ-002 CNT_W, 24, width of window error accumulator and result.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 aligned  input  1  link-lock flag from the alignment/PRBS check stage.
REQ-006 errorCounter  input  7  bit errors in the current 64-bit word (0..64; >64 treated as 64).
REQ-007 win_sel  input  4  window length = 1024 << win_sel words; values >10 clamp to 10.
REQ-008 clear  input  1  one-cycle pulse; clears lock_loss_count and overrun, restarts the window.
REQ-009 res_ack  input  1  consumer acknowledge of the result.
REQ-010 res_valid  output  1  window result available; held until acknowledged.
REQ-011 res_err  output  CNT_W  error total of the completed window.
REQ-012 res_words  output  4  win_sel value (post-clamp) used for that window.
REQ-013 overrun  output  1  sticky; a window completed while res_valid was still high.
REQ-014 lock_loss_count  output  8  saturating count of aligned 1->0 transitions.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 SETTLE, 2 MEASURE.

Function
REQ-016 FSM transitions: IDLE->SETTLE when aligned=1; SETTLE->MEASURE after SETTLE_CYCLES consecutive aligned=1 cycles; any state->IDLE whenever aligned=0.
REQ-017 Leaving SETTLE or MEASURE because aligned=0 increments lock_loss_count by 1 (saturating at 255) and discards the partial window; no result is produced.
REQ-018 win_sel is latched on entry to MEASURE and on each window restart; changes mid-window take effect only at the next window.
REQ-019 In MEASURE, each cycle adds errorCounter (clamped to 64) to the accumulator and increments the word counter; the accumulator saturates at 2^CNT_W-1.
REQ-020 On the last word of a window (word counter = length-1), the final sum includes that cycle's errorCounter; res_err/res_words load and res_valid rises on the next clock edge (latency 1).
REQ-021 The next window starts on the cycle after the last word with a zeroed accumulator and no gap words.
REQ-022 Handshake: result transfers on any cycle with res_valid=1 and res_ack=1; res_valid falls the following cycle unless a new result loads in that same cycle.
REQ-023 A new result while res_valid=1 and res_ack=0 overwrites res_err/res_words, keeps res_valid=1, and sets overrun.
REQ-024 A new result in the same cycle as an ack loads normally, keeps res_valid=1, and does not set overrun.
REQ-025 clear: accumulator and word counter zeroed, lock_loss_count=0, overrun=0; FSM and pending res_valid unaffected; clear has priority over accumulation and lock-loss increment in the same cycle.
REQ-026 res_ack while res_valid=0 has no effect.

Reset
REQ-027 While reset=0 at a clock edge: state=IDLE, res_valid=0, res_err=0, res_words=0, overrun=0, lock_loss_count=0, accumulator/word/settle counters=0.
REQ-028 Reset asserted mid-window discards the window with no result and no lock-loss increment; operation resumes from IDLE on the first edge with reset=1.

Verification
REQ-029 aligned=1 from cycle 0, win_sel=0, errorCounter=1 constant, SETTLE_CYCLES=16 -> state=MEASURE after 16 cycles; res_valid rises 1 cycle after the 1024th measured word with res_err=1024, res_words=0.
REQ-030 errorCounter=64 every word, win_sel=10, CNT_W=16 -> res_err=16'hFFFF (saturated).
REQ-031 aligned drops at measured word 500 of a 1024 window -> no res_valid, lock_loss_count=1, state=IDLE next cycle; resumes settle on re-lock.
REQ-032 res_ack held 0 across two completed windows (errors 5 then 7) -> res_err=7, res_valid=1, overrun=1; ack -> res_valid=0 next cycle, overrun stays 1 until clear.
REQ-033 256 lock losses -> lock_loss_count=255; clear pulse -> lock_loss_count=0, overrun=0.
REQ-034 win_sel changed 0->1 at measured word 100 -> current window result has res_words=0 after 1024 words; next window has res_words=1 and spans 2048 words.
